// File: rtl/chain_control_ingr_reg_pkg.sv
// Shared constants for the ingress control register file: AXI response codes,
// address-map bases and the word index of every field in the control vector.
package chain_control_ingr_reg_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_BASE = 'h000;
    localparam int STAT_BASE = 'h080;
    localparam int MAP_LIMIT = 'h100;

    // Word positions inside reg_out consumed by the field-slicing stage
    localparam int AP_START_WORD     = 0;
    localparam int BUF_BASE_WORD     = 1;
    localparam int BUF_OFFSET_WORD   = 5;
    localparam int FWD_TABLE_WORD    = 9;
    localparam int UPDREQ_WORD       = 13;
    localparam int FAULT_INSERT_WORD = 14;

endpackage

// File: rtl/chain_control_axil_slave_if.sv
// AXI4-Lite slave handshake engine: write/read FSMs that hand the parent
// single-cycle commit and lookup strobes, and register the responses it returns.
module chain_control_axil_slave_if
    import chain_control_ingr_reg_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    input  logic [1:0]        wr_resp,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    input  logic [1:0]        rd_resp
);

    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_WAIT_W  = 2'd1;
    localparam logic [1:0] W_WAIT_AW = 2'd2;
    localparam logic [1:0] W_RESP    = 2'd3;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    logic [1:0]        wstate_reg, wstate_next;
    logic [0:0]        rstate_reg;
    logic              active_reg;
    logic [ADDR_W-1:0] awaddr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic [1:0]        bresp_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;
    logic              aw_hs, w_hs;

    // Readies stay low while in reset and for the first cycle after release
    assign s_axi_awready = active_reg && (wstate_reg == W_IDLE || wstate_reg == W_WAIT_AW);
    assign s_axi_wready  = active_reg && (wstate_reg == W_IDLE || wstate_reg == W_WAIT_W);
    assign s_axi_bvalid  = (wstate_reg == W_RESP);
    assign s_axi_bresp   = bresp_reg;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;

    // Whichever channel arrived first comes from its latch, the other from the bus
    assign wr_addr = (wstate_reg == W_WAIT_W)  ? awaddr_reg : s_axi_awaddr;
    assign wr_data = (wstate_reg == W_WAIT_AW) ? wdata_reg  : s_axi_wdata;
    assign wr_strb = (wstate_reg == W_WAIT_AW) ? wstrb_reg  : s_axi_wstrb;

    always_comb begin
        wstate_next = wstate_reg;
        wr_en       = 1'b0;
        case (wstate_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en       = 1'b1;
                    wstate_next = W_RESP;
                end else if (aw_hs) begin
                    wstate_next = W_WAIT_W;
                end else if (w_hs) begin
                    wstate_next = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                if (w_hs) begin
                    wr_en       = 1'b1;
                    wstate_next = W_RESP;
                end
            end
            W_WAIT_AW: begin
                if (aw_hs) begin
                    wr_en       = 1'b1;
                    wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) wstate_next = W_IDLE;
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            wstate_reg <= W_IDLE;
            awaddr_reg <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            bresp_reg  <= RESP_OKAY;
        end else begin
            active_reg <= 1'b1;
            wstate_reg <= wstate_next;
            if (aw_hs) awaddr_reg <= s_axi_awaddr;
            if (w_hs) begin
                wdata_reg <= s_axi_wdata;
                wstrb_reg <= s_axi_wstrb;
            end
            if (wr_en) bresp_reg <= wr_resp;
        end
    end

    assign s_axi_arready = active_reg && (rstate_reg == R_IDLE);
    assign rd_en         = s_axi_arvalid && s_axi_arready;
    assign rd_addr       = s_axi_araddr;
    assign s_axi_rvalid  = (rstate_reg == R_DATA);
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_reg <= R_IDLE;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (rd_en) begin
            rdata_reg  <= rd_data;
            rresp_reg  <= rd_resp;
            rstate_reg <= R_DATA;
        end else if (rstate_reg == R_DATA && s_axi_rready) begin
            rstate_reg <= R_IDLE;
        end
    end

endmodule

// File: rtl/chain_control_ingr_reg_file.sv
// Ingress control register file: 32 R/W control words driving reg_out, 32 RO
// status words from reg_in, and a request word whose bits hardware can clear.
module chain_control_ingr_reg_file #(
    parameter int ADDR_W      = 12,
    parameter int NWORDS      = 32,
    parameter int UPDREQ_WORD = 13
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic [32*NWORDS-1:0]  reg_out,
    input  logic [32*NWORDS-1:0]  reg_in,
    input  logic [31:0]           ingr_forward_update_ack
);
    import chain_control_ingr_reg_pkg::RESP_OKAY;
    import chain_control_ingr_reg_pkg::RESP_SLVERR;
    import chain_control_ingr_reg_pkg::STAT_BASE;
    import chain_control_ingr_reg_pkg::MAP_LIMIT;

    localparam int                IDX_W   = $clog2(NWORDS);
    localparam logic [ADDR_W-1:0] STAT_LO = ADDR_W'(STAT_BASE);
    localparam logic [ADDR_W-1:0] MAP_HI  = ADDR_W'(MAP_LIMIT);

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data, rd_data, wr_mask;
    logic [3:0]        wr_strb;
    logic [1:0]        wr_resp, rd_resp;
    logic              wr_ctrl;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              unused_addr_lsbs;

    logic [NWORDS-1:0][31:0] ctrl_words;
    logic [NWORDS-1:0][31:0] stat_words;

    chain_control_axil_slave_if #(
        .ADDR_W (ADDR_W)
    ) u_axil (
        .clk           (ap_clk),
        .rst_n         (ap_rst_n),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_resp       (wr_resp),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_resp       (rd_resp)
    );

    assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

    assign wr_ctrl = (wr_addr < STAT_LO);
    assign wr_resp = wr_ctrl ? RESP_OKAY : RESP_SLVERR;
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign rd_idx  = rd_addr[IDX_W+1:2];
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            logic [31:0] set_bits;
            logic        hit;

            assign hit      = wr_en && wr_ctrl && (wr_idx == IDX_W'(gi));
            assign set_bits = hit ? (wr_data & wr_mask) : 32'h0;

            if (gi == UPDREQ_WORD) begin : g_updreq
                // Ack clears after the byte merge, then written ones are re-applied so software wins
                always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                    if (!ap_rst_n) begin
                        word_reg <= '0;
                    end else begin
                        word_reg <= ((hit ? (word_reg & ~wr_mask) : word_reg)
                                     & ~ingr_forward_update_ack) | set_bits;
                    end
                end
            end else begin : g_plain
                always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                    if (!ap_rst_n) begin
                        word_reg <= '0;
                    end else if (hit) begin
                        word_reg <= (word_reg & ~wr_mask) | set_bits;
                    end
                end
            end

            assign ctrl_words[gi] = word_reg;
        end
    endgenerate

    assign reg_out    = ctrl_words;
    assign stat_words = reg_in;

    // Looked up in the handshake cycle; control words therefore read pre-write
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (rd_addr < STAT_LO) begin
            rd_data = ctrl_words[rd_idx];
        end else if (rd_addr < MAP_HI) begin
            rd_data = stat_words[rd_idx];
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

endmodule
